shift_reg_univ: RTL and testbench
=================================

// Module: shift_reg_univ
// PURPOSE
//  Parametrised universal register: hold, parallel load, shift and rotate in both
//  directions, plus a self-timed burst mode that serialises a loaded word while
//  capturing a serial input word (full duplex, SPI-style).
//  Sits between parallel datapath registers and serial links as the general load/shift stage.
// PARAMETERS
//  WIDTH      16   register width in bits, >= 2
//  RESET_VAL  0    value of store after reset (WIDTH bits)
//  MSB_FIRST  1    1: ser_out = store[WIDTH-1], burst shifts left; 0: ser_out = store[0], burst shifts right
// PORTS
//  clk      in   1      single clock, rising edge
//  rst_n    in   1      reset, asynchronous, active-low
//  data     in   WIDTH  parallel load value
//  en       in   1      qualifies mode in IDLE
//  mode     in   3      000 hold, 001 load, 010 shl, 011 shr, 100 rol, 101 ror, 11x hold
//  ser_in   in   1      serial input, for shifts and burst capture
//  start    in   1      begin burst; sampled only in IDLE
//  out      out  WIDTH  current register contents
//  ser_out  out  1      serial output bit (see MSB_FIRST)
//  busy     out  1      high for the whole burst
//  done     out  1      one-cycle pulse after the last burst shift
// BEHAVIOUR
//  Reset (rst_n=0, any time, including mid-burst):
//   - store=RESET_VAL, state=IDLE, cnt=0, done=0
//   - outputs follow at once: out=RESET_VAL, busy=0; ser_out = the selected bit of RESET_VAL
//  Registered state: store, state {IDLE, SHIFT}, cnt [$clog2(WIDTH)-1:0], done.
//  IDLE priority at each edge:
//   - start=1: store<=data, cnt<=0, state<=SHIFT
//   - else en=1: apply mode; result visible on out the next cycle (1-cycle latency)
//   - else: hold
//  Mode rules:
//   - shl: {store[W-2:0],ser_in}; shr: {ser_in,store[W-1:1]}
//   - rol: {store[W-2:0],store[W-1]}; ror: {store[0],store[W-1:1]}
//   - reserved codes (11x) hold
//  SHIFT state, one bit per edge:
//   - store shifts toward ser_out (shl if MSB_FIRST, else shr) and takes in ser_in
//   - cnt<=cnt+1
//   - at the edge where cnt==WIDTH-1: state<=IDLE, done<=1
//   - busy = (state==SHIFT) for exactly WIDTH cycles
//   - data bit k is on ser_out during SHIFT cycle k
//   - ser_in is sampled at each of the WIDTH shift edges
//  After a burst, out holds the WIDTH captured ser_in bits. The first captured bit
//   ends at the MSB if MSB_FIRST, else at the LSB.
//  done is high for the one cycle after the burst; otherwise 0.
//  During SHIFT, start, en, mode and data are ignored; a start during busy is dropped, not queued.
//  start is accepted in the done cycle, so back-to-back bursts leave a 1-cycle gap.
//  All arithmetic is unsigned. cnt does not wrap within a burst.
// STRUCTURE
//  - shift_reg_pkg: mode encodings (MODE_HOLD..MODE_ROR) and state encodings, shared
//    with the other register blocks and the bench.
//  - Sub-module shift_burst_ctrl: IDLE/SHIFT FSM, cnt, busy, done; emits a shift_en strobe.
//  - The top holds the store register and the mode multiplexer.
// TESTING (WIDTH=16, MSB_FIRST=1 unless stated)
//  1. Load: en=1, mode=001, data=16'hA5C3 -> out=16'hA5C3 after 1 edge.
//     Then en=0 for 5 cycles -> out stays 16'hA5C3.
//  2. Shift/rotate: out=16'h8001, shl with ser_in=1 -> 16'h0003.
//     Load 16'h0001, ror -> 16'h8000; rol -> 16'h0001; mode=110 -> hold.
//  3. Burst: start=1, data=16'hA5C3, ser_in driven with 16'h1234 MSB-first.
//     Required: ser_out = bits of A5C3 MSB-first; busy=1 for 16 cycles; done=1 for 1 cycle;
//     then out=16'h1234.
//  4. Burst interference: start, en=1 and mode=001 pulsed at burst cycles 3 and 10 ->
//     no effect; out and ser_out sequence identical to test 3.
//  5. Reset mid-burst: rst_n=0 asynchronously at burst cycle 7 -> out=0, busy=0, done=0 at once.
//     After release, the next start runs a full 16-cycle burst.
//  6. MSB_FIRST=0, WIDTH=8: burst of 8'h96, ser_in = 8'h5A LSB-first ->
//     ser_out = LSB-first bits of 8'h96; out=8'h5A; done pulse at cycle 8.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: mode and burst-state encodings shared by the register blocks and benches
package shift_reg_pkg;
  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101
  } mode_e;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;
endpackage

// File: rtl/shift_reg_univ_if.sv
// shift_reg_univ_if: parallel/serial data and burst handshake of the universal register
interface shift_reg_univ_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] data;
  logic             en;
  logic [2:0]       mode;
  logic             ser_in;
  logic             start;
  logic [WIDTH-1:0] out;
  logic             ser_out;
  logic             busy;
  logic             done;
  modport master (output data, en, mode, ser_in, start, input out, ser_out, busy, done);
  modport slave  (input data, en, mode, ser_in, start, output out, ser_out, busy, done);
endinterface

// File: rtl/shift_burst_ctrl.sv
// shift_burst_ctrl: IDLE/SHIFT burst sequencer producing load/shift strobes, busy and done
module shift_burst_ctrl
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic load,
  output logic shift_en,
  output logic busy,
  output logic done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_e state;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          cnt   <= '0;
          state <= ST_SHIFT;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
      end
    end
  assign busy     = state == ST_SHIFT;
  assign shift_en = busy;
  assign load     = !busy && start;
endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal hold/load/shift/rotate register with self-timed full-duplex burst
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int             WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit             MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst_n,
  shift_reg_univ_if.slave bus
);
  logic [WIDTH-1:0] store, nxt, shl_v, shr_v, rol_v, ror_v, mode_v;
  logic load, shift_en;
  shift_burst_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk, .rst_n, .start(bus.start), .load, .shift_en, .busy(bus.busy), .done(bus.done)
  );
  assign shl_v = {store[WIDTH-2:0], bus.ser_in};
  assign shr_v = {bus.ser_in, store[WIDTH-1:1]};
  assign rol_v = {store[WIDTH-2:0], store[WIDTH-1]};
  assign ror_v = {store[0], store[WIDTH-1:1]};
  assign mode_v = bus.mode == MODE_LOAD ? bus.data :
                  bus.mode == MODE_SHL  ? shl_v :
                  bus.mode == MODE_SHR  ? shr_v :
                  bus.mode == MODE_ROL  ? rol_v :
                  bus.mode == MODE_ROR  ? ror_v : store;
  // burst start wins over en; during a burst only the serial shift applies
  assign nxt = load ? bus.data : shift_en ? (MSB_FIRST ? shl_v : shr_v) : bus.en ? mode_v : store;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) store <= RESET_VAL;
    else store <= nxt;
  assign bus.out     = store;
  assign bus.ser_out = MSB_FIRST ? store[WIDTH-1] : store[0];
endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: directed checks of a 16-bit MSB-first and an 8-bit LSB-first instance
module tb_shift_reg_univ;
  import shift_reg_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  shift_reg_univ_if #(.WIDTH(16)) d ();
  shift_reg_univ_if #(.WIDTH(8))  e ();
  shift_reg_univ #(.WIDTH(16), .RESET_VAL(16'h0), .MSB_FIRST(1'b1)) u16 (.clk(clk), .rst_n(rst_n), .bus(d));
  shift_reg_univ #(.WIDTH(8),  .RESET_VAL(8'h0),  .MSB_FIRST(1'b0)) u8  (.clk(clk), .rst_n(rst_n), .bus(e));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic burst16(input logic [15:0] dv, input logic [15:0] sv, input bit interfere);
    logic [15:0] so;
    int busy_n, done_n;
    busy_n = 0;
    done_n = 0;
    d.start = 1'b1;
    d.data  = dv;
    tick();
    d.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      so[15-k] = d.ser_out;
      busy_n += int'(d.busy);
      done_n += int'(d.done);
      d.ser_in = sv[15-k];
      d.start  = interfere && (k == 3 || k == 10);
      d.en     = d.start;
      d.mode   = d.start ? MODE_LOAD : MODE_HOLD;
      d.data   = d.start ? 16'hFFFF : dv;
      tick();
    end
    d.start = 1'b0;
    d.en = 1'b0;
    chk("burst_ser_out", 32'(so), 32'(dv));
    chk("burst_busy_cycles", 32'(busy_n), 32'd16);
    chk("burst_done_early", 32'(done_n), 32'd0);
    chk("burst_done", 32'(d.done), 32'd1);
    chk("burst_busy_end", 32'(d.busy), 32'd0);
    chk("burst_capture", 32'(d.out), 32'(sv));
  endtask

  initial begin
    logic [7:0] so8;
    d.data = '0; d.en = 0; d.mode = MODE_HOLD; d.ser_in = 0; d.start = 0;
    e.data = '0; e.en = 0; e.mode = MODE_HOLD; e.ser_in = 0; e.start = 0;
    #3;
    chk("rst_out", 32'(d.out), 32'h0);
    chk("rst_busy", 32'(d.busy), 32'h0);
    chk("rst_done", 32'(d.done), 32'h0);
    chk("rst_ser_out", 32'(d.ser_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // load then idle hold
    d.en = 1; d.mode = MODE_LOAD; d.data = 16'hA5C3;
    tick();
    chk("load", 32'(d.out), 32'hA5C3);
    d.en = 0;
    repeat (5) tick();
    chk("hold_en0", 32'(d.out), 32'hA5C3);
    // shifts and rotates
    d.en = 1; d.data = 16'h8001;
    tick();
    d.mode = MODE_SHL; d.ser_in = 1;
    tick();
    chk("shl", 32'(d.out), 32'h0003);
    d.mode = MODE_SHR; d.ser_in = 1;
    tick();
    chk("shr", 32'(d.out), 32'h8001);
    d.mode = MODE_LOAD; d.data = 16'h0001; d.ser_in = 0;
    tick();
    d.mode = MODE_ROR;
    tick();
    chk("ror", 32'(d.out), 32'h8000);
    d.mode = MODE_ROL;
    tick();
    chk("rol", 32'(d.out), 32'h0001);
    d.mode = 3'b110;
    tick();
    chk("reserved_hold", 32'(d.out), 32'h0001);
    d.en = 0;
    // plain burst, then an interfered one started in the done cycle
    burst16(16'hA5C3, 16'h1234, 1'b0);
    burst16(16'hA5C3, 16'h1234, 1'b1);
    tick();
    chk("done_pulse_end", 32'(d.done), 32'h0);
    // asynchronous reset mid-burst
    d.start = 1; d.data = 16'hA5C3;
    tick();
    d.start = 0;
    repeat (7) tick();
    chk("mid_busy", 32'(d.busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(d.out), 32'h0);
    chk("async_rst_busy", 32'(d.busy), 32'h0);
    chk("async_rst_done", 32'(d.done), 32'h0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    burst16(16'hC3A5, 16'h0F0F, 1'b0);
    // LSB-first 8-bit burst
    e.start = 1; e.data = 8'h96;
    tick();
    e.start = 0;
    for (int k = 0; k < 8; k++) begin
      so8[k] = e.ser_out;
      chk("b8_busy", 32'(e.busy), 32'h1);
      e.ser_in = k[0] ? 1'b1 : 1'b0;
      e.ser_in = 8'h5A >> k & 8'h1 ? 1'b1 : 1'b0;
      tick();
    end
    chk("b8_ser_out", 32'(so8), 32'h96);
    chk("b8_capture", 32'(e.out), 32'h5A);
    chk("b8_done", 32'(e.done), 32'h1);
    chk("b8_busy_end", 32'(e.busy), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
